// File: rtl/icache_if.sv
// ============================================================================
// Module      : icache_if
// Description : Fetch-side and memory-side bus bundle for the icache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] proc2Icache_addr;
    logic [63:0]     Icache2proc_data;
    logic            Icache2proc_data_valid;
    logic [1:0]      proc2Imem_command;
    logic [XLEN-1:0] proc2Imem_addr;
    logic [3:0]      Imem2proc_response;
    logic [63:0]     Imem2proc_data;
    logic [3:0]      Imem2proc_tag;

    modport slave (
        input  proc2Icache_addr,
        input  Imem2proc_response,
        input  Imem2proc_data,
        input  Imem2proc_tag,
        output Icache2proc_data,
        output Icache2proc_data_valid,
        output proc2Imem_command,
        output proc2Imem_addr
    );

    modport master (
        output proc2Icache_addr,
        output Imem2proc_response,
        output Imem2proc_data,
        output Imem2proc_tag,
        input  Icache2proc_data,
        input  Icache2proc_data_valid,
        input  proc2Imem_command,
        input  proc2Imem_addr
    );
endinterface

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache, 8-byte lines, one miss in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
    parameter int NUM_LINES = 32,
    parameter int XLEN      = 32
) (
    input  logic     clock,
    input  logic     reset,
    icache_if.slave  bus
);
    localparam int c_idx_w = $clog2(NUM_LINES);
    localparam int c_tag_w = XLEN - 3 - c_idx_w;

    localparam logic [1:0] c_bus_none = 2'h0;
    localparam logic [1:0] c_bus_load = 2'h1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    logic [63:0]          r_data  [NUM_LINES];
    logic [c_tag_w-1:0]   r_tag   [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [1:0]           r_state;
    logic [XLEN-1:0]      r_miss_addr;
    logic [3:0]           r_mem_tag;

    logic [c_idx_w-1:0]   w_idx;
    logic [c_tag_w-1:0]   w_tag;
    logic [c_idx_w-1:0]   w_miss_idx;
    logic [c_tag_w-1:0]   w_miss_tag;
    logic                 w_hit;
    logic                 w_fill;
    logic                 w_redirect;

    assign w_idx      = bus.proc2Icache_addr[3+c_idx_w-1:3];
    assign w_tag      = bus.proc2Icache_addr[XLEN-1:3+c_idx_w];
    assign w_miss_idx = r_miss_addr[3+c_idx_w-1:3];
    assign w_miss_tag = r_miss_addr[XLEN-1:3+c_idx_w];

    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // mem_tag is never 0 in WAIT, but the explicit guard keeps "no data" cycles inert
    assign w_fill     = (r_state == c_st_wait) && (bus.Imem2proc_tag != 4'd0)
                        && (bus.Imem2proc_tag == r_mem_tag);
    assign w_redirect = bus.proc2Icache_addr[XLEN-1:3] != r_miss_addr[XLEN-1:3];

    // Fill data is visible only from the cycle after the write edge (no bypass)
    assign bus.Icache2proc_data       = r_data[w_idx];
    assign bus.Icache2proc_data_valid = w_hit;
    assign bus.proc2Imem_command      = (r_state == c_st_req) ? c_bus_load : c_bus_none;
    assign bus.proc2Imem_addr         = r_miss_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_miss_addr <= '0;
            r_mem_tag   <= 4'd0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_hit) begin
                        r_miss_addr <= {bus.proc2Icache_addr[XLEN-1:3], 3'b000};
                        r_state     <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (bus.Imem2proc_response != 4'd0) begin
                        r_mem_tag <= bus.Imem2proc_response;
                        r_state   <= c_st_wait;
                    end else if (w_redirect) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_wait: begin
                    if (w_fill) begin
                        r_valid[w_miss_idx] <= 1'b1;
                        r_state             <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_fill) begin
            r_data[w_miss_idx] <= bus.Imem2proc_data;
            r_tag[w_miss_idx]  <= w_miss_tag;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache: miss flows, hit table, corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;
    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    icache_if #(.XLEN(32)) bus ();

    icache #(.NUM_LINES(32), .XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic [1:0]  exp_cmd;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] q_addr [$];
    logic [63:0] q_data [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag      = 4'd0;
        bus.Imem2proc_data     = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(bus.Icache2proc_data_valid), 64'd0);
        check("rst_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        check("rst_miss_addr", 64'(bus.proc2Imem_addr), 64'd0);
    endtask

    // Full miss: cycle 0 detect, nretry rejected LOADs, accept, gap idle cycles, fill, hit.
    task automatic miss_txn(input logic [31:0] addr, input logic [63:0] data,
                            input logic [3:0] rtag, input int nretry, input int gap);
        logic [31:0] line;
        line = {addr[31:3], 3'b000};
        bus.proc2Icache_addr   = addr;
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag      = 4'd0;
        #1;
        check("miss_valid", 64'(bus.Icache2proc_data_valid), 64'd0);
        check("miss_c0_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        q_addr.push_back(line);
        tick();
        for (int i = 0; i <= nretry; i++) begin
            check("req_cmd", 64'(bus.proc2Imem_command), 64'(BUS_LOAD));
            if (i == 0) begin
                if (q_addr.size() == 0) check("req_addr_queue", 64'd0, 64'd1);
                else check("req_addr", 64'(bus.proc2Imem_addr), 64'(q_addr.pop_front()));
            end else begin
                check("retry_addr", 64'(bus.proc2Imem_addr), 64'(line));
            end
            bus.Imem2proc_response = (i == nretry) ? rtag : 4'd0;
            tick();
        end
        bus.Imem2proc_response = 4'd0;
        for (int i = 0; i < gap; i++) begin
            check("wait_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
            check("wait_valid", 64'(bus.Icache2proc_data_valid), 64'd0);
            tick();
        end
        bus.Imem2proc_tag  = rtag;
        bus.Imem2proc_data = data;
        q_data.push_back(data);
        #1;
        check("fill_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        check("no_bypass", 64'(bus.Icache2proc_data_valid), 64'd0);
        tick();
        bus.Imem2proc_tag  = 4'd0;
        bus.Imem2proc_data = '0;
        #1;
        check("fill_valid", 64'(bus.Icache2proc_data_valid), 64'd1);
        if (q_data.size() == 0) check("fill_data_queue", 64'd0, 64'd1);
        else check("fill_data", bus.Icache2proc_data, q_data.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 1'b1, 64'h1111_2222_3333_4444, BUS_NONE};
        vecs[1] = '{32'h0000_0104, 1'b1, 64'h1111_2222_3333_4444, BUS_NONE};
        vecs[2] = '{32'h0000_0208, 1'b1, 64'hBBBB_0000_CCCC_0001, BUS_NONE};
        vecs[3] = '{32'h0000_020C, 1'b1, 64'hBBBB_0000_CCCC_0001, BUS_NONE};
        vecs[4] = '{32'h0000_0108, 1'b0, 64'h0, BUS_NONE};
        vecs[5] = '{32'h0000_1100, 1'b0, 64'h0, BUS_LOAD};
        vecs[6] = '{32'h0000_0300, 1'b0, 64'h0, BUS_NONE};
        vecs[7] = '{32'h0000_0100, 1'b1, 64'h1111_2222_3333_4444, BUS_LOAD};

        bus.proc2Icache_addr   = 32'h0;
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag      = 4'd0;
        bus.Imem2proc_data     = '0;

        // Cold miss: accept in cycle 1, data in cycle 5, hit from cycle 6
        do_reset();
        miss_txn(32'h0000_0100, 64'h1111_2222_3333_4444, 4'd3, 0, 3);

        // Three rejects then accept: LOAD held four cycles
        do_reset();
        miss_txn(32'h0000_0100, 64'h1111_2222_3333_4444, 4'd5, 3, 0);
        miss_txn(32'h0000_0208, 64'hBBBB_0000_CCCC_0001, 4'd1, 1, 2);

        for (int i = 0; i < 8; i++) begin
            bus.proc2Icache_addr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_valid", i), 64'(bus.Icache2proc_data_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_cmd", i), 64'(bus.proc2Imem_command), 64'(vecs[i].exp_cmd));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_data", i), bus.Icache2proc_data, vecs[i].exp_data);
            tick();
        end
        tick();

        // Conflict eviction on index 0
        miss_txn(32'h0000_1100, 64'hCCCC_1111_DDDD_2222, 4'd6, 0, 1);
        miss_txn(32'h0000_0100, 64'hAAAA_5555_AAAA_5555, 4'd2, 0, 0);
        bus.proc2Icache_addr = 32'h0000_1100;
        #1;
        check("evicted_1100", 64'(bus.Icache2proc_data_valid), 64'd0);
        bus.proc2Icache_addr = 32'h0000_0100;
        tick();

        // Redirect while waiting: fill of 0x100 still lands, then 0x200 misses
        do_reset();
        bus.proc2Icache_addr = 32'h0000_0100;
        tick();
        check("redir_load", 64'(bus.proc2Imem_command), 64'(BUS_LOAD));
        check("redir_addr", 64'(bus.proc2Imem_addr), 64'h100);
        bus.Imem2proc_response = 4'd2;
        tick();
        bus.Imem2proc_response = 4'd0;
        bus.proc2Icache_addr   = 32'h0000_0200;
        #1;
        check("redir_wait_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        tick();
        bus.Imem2proc_tag  = 4'd2;
        bus.Imem2proc_data = 64'hDEAD_BEEF_0123_4567;
        tick();
        bus.Imem2proc_tag  = 4'd0;
        #1;
        check("redir_idle_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        bus.proc2Icache_addr = 32'h0000_0100;
        #1;
        check("redir_old_valid", 64'(bus.Icache2proc_data_valid), 64'd1);
        check("redir_old_data", bus.Icache2proc_data, 64'hDEAD_BEEF_0123_4567);
        bus.proc2Icache_addr = 32'h0000_0200;
        #1;
        check("redir_new_miss", 64'(bus.Icache2proc_data_valid), 64'd0);
        tick();
        check("redir_new_load", 64'(bus.proc2Imem_command), 64'(BUS_LOAD));
        check("redir_new_addr", 64'(bus.proc2Imem_addr), 64'h200);

        // Tag filtering: tags 0 and 7 ignored while waiting on tag 4
        do_reset();
        bus.proc2Icache_addr = 32'h0000_0100;
        tick();
        bus.Imem2proc_response = 4'd4;
        tick();
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag      = 4'd0;
        bus.Imem2proc_data     = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        bus.Imem2proc_tag = 4'd7;
        tick();
        bus.Imem2proc_tag = 4'd0;
        #1;
        check("tagf_valid7", 64'(bus.Icache2proc_data_valid), 64'd0);
        check("tagf_cmd7", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        tick();
        check("tagf_still_wait", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        bus.Imem2proc_tag  = 4'd4;
        bus.Imem2proc_data = 64'h4444_0000_4444_0000;
        tick();
        bus.Imem2proc_tag = 4'd0;
        #1;
        check("tagf_valid4", 64'(bus.Icache2proc_data_valid), 64'd1);
        check("tagf_data4", bus.Icache2proc_data, 64'h4444_0000_4444_0000);

        // Reset mid-WAIT, stale tag returns afterwards
        do_reset();
        bus.proc2Icache_addr = 32'h0000_0100;
        tick();
        bus.Imem2proc_response = 4'd9;
        tick();
        bus.Imem2proc_response = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.Imem2proc_tag  = 4'd9;
        bus.Imem2proc_data = 64'hFFFF_EEEE_DDDD_CCCC;
        #1;
        check("rstw_miss_addr", 64'(bus.proc2Imem_addr), 64'd0);
        check("rstw_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
        tick();
        #1;
        check("rstw_valid1", 64'(bus.Icache2proc_data_valid), 64'd0);
        tick();
        bus.Imem2proc_tag = 4'd0;
        #1;
        check("rstw_valid2", 64'(bus.Icache2proc_data_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL take parameter NUM_LINES, default 32, the number of direct-mapped 8-byte lines; it must be a power of 2 and at least 2.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port list:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- proc2Icache_addr  input  XLEN  fetch address from the fetch stage; bits [2:0] are ignored.
- Icache2proc_data  output  64  line data for proc2Icache_addr.
- Icache2proc_data_valid  output  1  Icache2proc_data is valid this cycle.
- proc2Imem_command  output  2  BUS_NONE or BUS_LOAD.
- proc2Imem_addr  output  XLEN  miss line address, bits [2:0] = 0.
- Imem2proc_response  input  4  nonzero = request accepted, carrying its tag; 0 = rejected.
- Imem2proc_data  input  64  returned memory line.
- Imem2proc_tag  input  4  tag of Imem2proc_data; 0 = no data this cycle.

Function
REQ-004 Address decomposition: index = addr[3+log2(NUM_LINES)-1:3]; tag = addr[XLEN-1:3+log2(NUM_LINES)].
REQ-005 Per line the block SHALL store a 64-bit data word, a tag and a valid bit.
REQ-006 A hit is a valid line at the current index whose stored tag equals the current tag.
- On a hit, Icache2proc_data_valid SHALL be 1 and Icache2proc_data SHALL be the line data, both combinationally in the same cycle.
- Otherwise valid SHALL be 0.
REQ-007 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-008 In IDLE, a miss SHALL latch the full line address into miss_addr and move to REQ at the next edge; no command is issued in that cycle.
REQ-009 In REQ:
- proc2Imem_command SHALL be BUS_LOAD and proc2Imem_addr SHALL be miss_addr.
- A nonzero Imem2proc_response SHALL latch that value into mem_tag and move to WAIT.
- A zero response SHALL cause a retry in the next cycle.
REQ-010 In REQ, if proc2Icache_addr's line address differs from miss_addr and the response is 0, the FSM SHALL return to IDLE (miss abandoned); if the response is nonzero, the FSM SHALL go to WAIT as normal.
REQ-011 In WAIT:
- proc2Imem_command SHALL be BUS_NONE.
- When Imem2proc_tag equals mem_tag (nonzero), Imem2proc_data SHALL be written to the line at miss_addr's index, with miss_addr's tag and the valid bit set, at that edge, and the FSM SHALL go to IDLE.
- A tag of 0 or a mismatching tag SHALL be ignored.
REQ-012 The WAIT fill SHALL complete even if proc2Icache_addr has changed; the block SHALL never issue a second request while one is outstanding.
REQ-013 Filled data SHALL NOT be bypassed: a hit on filled data SHALL first appear in the cycle after the fill edge.
REQ-014 Minimum miss latency: miss detected in cycle 0 -> BUS_LOAD in cycle 1 -> data with a matching tag in cycle k >= 2 -> valid in cycle k+1.
REQ-015 A fill SHALL overwrite the existing line at that index regardless of its prior tag or valid state (direct-mapped eviction).
REQ-016 Outside REQ, proc2Imem_command SHALL be BUS_NONE and proc2Imem_addr SHALL be miss_addr.

Reset
REQ-017 On reset:
- all line valid bits SHALL clear and the FSM SHALL enter IDLE;
- miss_addr and mem_tag SHALL clear to 0;
- Icache2proc_data_valid SHALL be 0 and proc2Imem_command SHALL be BUS_NONE in the first cycle after reset.
REQ-018 Reset asserted in REQ or WAIT SHALL abandon the miss, and a later data return carrying the old tag SHALL be ignored (mem_tag = 0).

Verification
REQ-019 Cold miss (NUM_LINES=32): addr 0x0000_0100, response 3 in cycle 1, tag 3 with data 0x1111_2222_3333_4444 in cycle 5 -> valid=1 with that data from cycle 6; only one BUS_LOAD is issued.
REQ-020 Retry: response 0 for 3 cycles, then 5 -> BUS_LOAD with addr 0x100 is held for 4 consecutive cycles, then command is BUS_NONE.
REQ-021 Conflict eviction:
- fill 0x100, then access 0x1100 (same index, different tag) -> miss, refill;
- a later access to 0x100 -> miss again.
REQ-022 Redirect in WAIT: miss on 0x100 accepted with tag 2, addr changes to 0x200, tag 2 returns -> line for 0x100 is filled, then a new miss on 0x200 is issued the following cycle.
REQ-023 Tag filtering: in WAIT with mem_tag 4, tags 0 and 7 arrive -> no fill and the FSM stays in WAIT; tag 4 arrives -> fill.
REQ-024 Reset mid-WAIT, then the old tag returns -> no line becomes valid and Icache2proc_data_valid stays 0.
